mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Wait-state memory responder: byte-addressed, little-endian word memory that answers
// each accepted load/store with a one-cycle ready strobe after a fixed number of wait states.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  mem_responder_clock_in,
  input  logic                  mem_responder_reset_in,
  input  logic                  mem_responder_req_in,
  input  logic                  mem_responder_we_in,
  input  logic [1:0]            mem_responder_size_in,
  input  logic                  mem_responder_unsigned_in,
  input  logic [31:0]           mem_responder_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_responder_wdata_in,
  output logic [DATA_WIDTH-1:0] mem_responder_rdata_out,
  output logic                  mem_responder_ready_out,
  output logic                  mem_responder_busy_out,
  output logic                  mem_responder_err_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic                    r_unsigned;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH+1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                    w_idle;
  logic                    w_we;
  logic                    w_unsigned;
  logic [1:0]              w_size;
  logic [ADDR_WIDTH+1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [1:0]              w_lane;
  logic                    w_err;
  logic                    w_commit;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wlane;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_byte_sh;
  logic [DATA_WIDTH-1:0]   w_half_sh;
  logic [DATA_WIDTH-1:0]   w_load;
  logic                    w_unused_addr;

  // With zero wait states the commit edge is the accept edge, so the live inputs are used there.
  assign w_idle     = (r_state == IDLE);
  assign w_we       = w_idle ? mem_responder_we_in       : r_we;
  assign w_unsigned = w_idle ? mem_responder_unsigned_in : r_unsigned;
  assign w_size     = w_idle ? mem_responder_size_in     : r_size;
  assign w_addr     = w_idle ? mem_responder_addr_in[ADDR_WIDTH+1:0] : r_addr;
  assign w_wdata    = w_idle ? mem_responder_wdata_in    : r_wdata;
  assign w_idx      = w_addr[ADDR_WIDTH+1:2];
  assign w_lane     = w_addr[1:0];
  assign w_err      = (w_size == 2'b11) ||
                      (w_size == 2'b01 && w_lane[0]) ||
                      (w_size == 2'b10 && w_lane != 2'b00);
  assign w_commit   = (w_next_state == RESP);
  assign w_unused_addr = &{1'b0, mem_responder_addr_in[31:ADDR_WIDTH+2]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (mem_responder_req_in) w_next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (r_cnt == 4'd0) w_next_state = RESP;
      RESP: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = w_wdata;
    case (w_size)
      2'b00: begin
        w_be[w_lane] = 1'b1;
        w_wlane      = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_old = r_mem[w_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_be[gi] ? w_wlane[8*gi +: 8] : w_old[8*gi +: 8];
    end
  endgenerate

  assign w_byte_sh = w_old >> {w_lane, 3'b000};
  assign w_half_sh = w_old >> {w_lane[1], 4'b0000};

  always_comb begin
    w_load = w_old;
    case (w_size)
      2'b00: w_load = w_unsigned ? {24'd0, w_byte_sh[7:0]}
                                 : {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      2'b01: w_load = w_unsigned ? {16'd0, w_half_sh[15:0]}
                                 : {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      default: w_load = w_old;
    endcase
  end

  // Gated by reset so a reset on the would-be RESP edge drops the store.
  always_ff @(posedge mem_responder_clock_in) begin
    if (mem_responder_reset_in && w_commit && w_we && !w_err)
      r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge mem_responder_clock_in) begin
    if (!mem_responder_reset_in) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_idle && w_next_state == WAIT)
        r_cnt <= WAIT_INIT;
      else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_idle && mem_responder_req_in) begin
        r_we       <= mem_responder_we_in;
        r_unsigned <= mem_responder_unsigned_in;
        r_size     <= mem_responder_size_in;
        r_addr     <= mem_responder_addr_in[ADDR_WIDTH+1:0];
        r_wdata    <= mem_responder_wdata_in;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? '0 : w_load;
      end
    end
  end

  assign mem_responder_rdata_out = r_rdata;
  assign mem_responder_ready_out = (r_state == RESP);
  assign mem_responder_busy_out  = (r_state != IDLE);
  assign mem_responder_err_out   = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed-vector bench for mem_responder (WAIT_CYCLES=2): latency, lane merging,
// extension, error handling, reset abort, address wrap and back-to-back spacing.
module tb_mem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(WC)) dut (
    .mem_responder_clock_in   (clk),
    .mem_responder_reset_in   (rst_n),
    .mem_responder_req_in     (req),
    .mem_responder_we_in      (we),
    .mem_responder_size_in    (size),
    .mem_responder_unsigned_in(uns),
    .mem_responder_addr_in    (addr),
    .mem_responder_wdata_in   (wdata),
    .mem_responder_rdata_out  (rdata),
    .mem_responder_ready_out  (ready),
    .mem_responder_busy_out   (busy),
    .mem_responder_err_out    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    bit seen;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      req = 1'b0; addr = ~a; wdata = ~d; uns = ~u;
      if (ready) seen = 1'b1;
    end
    check({tag, ".latency"}, n, WC + 1);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ".idle"}, {29'd0, ready, err, busy}, 32'd0);
    check({tag, ".hold"}, rdata, exp_rdata);
  endtask

  // Word store aborted by a reset sampled on the k-th edge after the accept edge.
  task automatic store_with_reset(input string tag, input logic [31:0] a, input logic [31:0] d,
                                  input int k);
    int pulses;
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = a; wdata = d;
    @(posedge clk);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check({tag, ".rst_outs"}, {28'd0, ready, err, busy, 1'b0}, 32'd0);
    check({tag, ".rst_rdata"}, rdata, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check({tag, ".no_ready"}, pulses, 0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    check("reset.outs", {29'd0, ready, err, busy}, 32'd0);
    check("reset.rdata", rdata, 32'd0);
    rst_n = 1'b1;

    access("st_word",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    access("ld_word",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    access("st_byte",   1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 32'h0,        1'b0);
    access("ld_sbyte",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0);
    access("ld_ubyte",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h000000A5, 1'b0);
    access("ld_word2",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'hA5ADBEEF, 1'b0);
    access("ld_sbyte0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    access("st_half",   1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, 32'h0,        1'b0);
    access("ld_shalf",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0);
    access("ld_uhalf",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0);
    access("ld_shalf0", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    access("ld_word3",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8001BEEF, 1'b0);

    access("st_w0",     1'b1, 2'b10, 1'b0, 32'h00, 32'h11223344, 32'h0,        1'b0);
    access("st_misw",   1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, 32'h0,        1'b1);
    access("ld_rsvd",   1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1);
    access("st_mish",   1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFFFFFF, 32'h0,        1'b1);
    access("ld_w0",     1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h11223344, 1'b0);

    access("st_w20",    1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0);
    access("ld_w20",    1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0);
    store_with_reset("rst_wait", 32'h20, 32'h12345678, 1);
    store_with_reset("rst_resp", 32'h20, 32'h12345678, 2);
    access("ld_w20b",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0);

    access("st_wrap",   1'b1, 2'b00, 1'b0, 32'h1010, 32'h12345655, 32'h0,      1'b0);
    access("ld_wrap",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h00000055, 1'b0);
    access("ld_wrapw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8001BE55, 1'b0);

    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
    @(posedge clk);
    pulses = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    req = 1'b0;
    check("held.pulses", pulses, 4);
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("held.drain", {31'd0, busy}, 32'd0);
    check("held.rdata", rdata, 32'h8001BE55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
